// File: rtl/sd_pkt_commit_ctl.sv
// Write-side packet controller in front of a commit/abort FIFO: forwards framed words,
// commits good packets, aborts and discards errored or over-length ones. Optional stats: SD_PKTCTL_STATS_EN.
module sd_pkt_commit_ctl #(
  parameter int width   = 16,
  parameter int max_len = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  input  logic             c_eop,
  input  logic             c_err,
  output logic             f_srdy,
  input  logic             f_drdy,
  output logic [width-1:0] f_data,
  output logic             f_commit,
  output logic             f_abort,
  output logic [15:0]      pkt_count,
  output logic [15:0]      drop_count
);

  localparam int lsz = $clog2(max_len + 1);
  localparam logic [lsz-1:0] LEN_MAX = lsz'(max_len);
  localparam logic [lsz-1:0] LEN_ONE = lsz'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_ABORT, ST_DROP} state_t;

  state_t         r_state, w_state_nxt;
  logic [lsz-1:0] r_len, w_len_nxt;
  logic           r_abort_eop, w_abort_eop_nxt;

  assign f_data = c_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_abort_eop <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_abort_eop <= w_abort_eop_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_abort_eop_nxt = r_abort_eop;
    f_srdy          = 1'b0;
    c_drdy          = 1'b0;
    f_commit        = 1'b0;
    f_abort         = 1'b0;
    case (r_state)
      ST_IDLE, ST_BODY: begin
        f_srdy = c_srdy;
        c_drdy = f_drdy;
        // Priority: error, then end-of-packet, then length limit.
        if (c_srdy && f_drdy) begin
          if (c_err) begin
            w_state_nxt     = ST_ABORT;
            w_abort_eop_nxt = c_eop;
            w_len_nxt       = '0;
          end else if (c_eop) begin
            f_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
            w_len_nxt   = '0;
          end else if (r_len + LEN_ONE == LEN_MAX) begin
            w_state_nxt     = ST_ABORT;
            w_abort_eop_nxt = 1'b0;
            w_len_nxt       = '0;
          end else begin
            w_state_nxt = ST_BODY;
            w_len_nxt   = r_len + LEN_ONE;
          end
        end
      end
      ST_ABORT: begin
        f_abort     = 1'b1;
        w_state_nxt = r_abort_eop ? ST_IDLE : ST_DROP;
      end
      ST_DROP: begin
        c_drdy = 1'b1;
        if (c_srdy && c_eop) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef SD_PKTCTL_STATS_EN
  logic [15:0] r_pkt_cnt, r_drop_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (f_commit) r_pkt_cnt <= sat_inc(r_pkt_cnt);
      if (r_state != ST_ABORT && w_state_nxt == ST_ABORT) r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign pkt_count  = r_pkt_cnt;
  assign drop_count = r_drop_cnt;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

endmodule
